// File: rtl/fp27_pkg.sv
// fp27 shared types: 27-bit float {sign, exp[7:0], frac[17:0]}, bias 127,
// plus the stage bundles of the fp_addsub_pipe datapath.
package fp27_pkg;

  localparam int EXP_W = 8;
  localparam int FRAC_W = 18;
  localparam int W = 1 + EXP_W + FRAC_W;
  localparam int BIAS = 127;
  localparam int SIG_W = FRAC_W + 1;
  localparam int AL_W = SIG_W + 3;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp27_t;

  localparam logic [W-1:0] FP27_PINF = 27'h3FC0000;
  localparam logic [W-1:0] FP27_QNAN = 27'h3FE0000;

  typedef struct packed {
    logic             byp;
    fp27_t            res;
    logic [2:0]       flg;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [AL_W-1:0]  ma;
    logic [AL_W-1:0]  mb;
  } al_ad_t;

  typedef struct packed {
    logic             byp;
    fp27_t            res;
    logic [2:0]       flg;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [AL_W:0]    sum;
  } ad_nm_t;

  // Significand right shift into {sig, guard, round, sticky}.
  function automatic logic [AL_W-1:0] align_sig(
    input logic [SIG_W-1:0] m,
    input logic [EXP_W-1:0] d
  );
    logic [AL_W-1:0] f, sh, lost;
    f = {m, 3'b000};
    sh = f >> d;
    lost = f & ~({AL_W{1'b1}} << d);
    if (d >= 8'(AL_W))
      return {{(AL_W-1){1'b0}}, 1'b1};
    return {sh[AL_W-1:1], sh[0] | (|lost)};
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter for the normalise stage of fp_addsub_pipe.
module fp_lzc (
  input  logic [22:0] d,
  output logic [4:0]  cnt
);

  logic done;

  always_comb begin
    cnt = '0;
    done = 1'b0;
    for (int i = 22; i >= 0; i--) begin
      if (!done) begin
        if (d[i]) done = 1'b1;
        else cnt = cnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// 3-stage fp27 add/sub: align, add, normalise; full stall on back-pressure.
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even instead of truncation.
module fp_addsub_pipe
  import fp27_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int FRAC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   op_a,
  input  logic [EXP_W+FRAC_W:0]   op_b,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic [2:0]              flags
);

  logic   adv;
  logic   v1, v2, v3;
  al_ad_t s1, al_d;
  ad_nm_t s2, ad_d;
  fp27_t  res_q, nres;
  logic [2:0] flg_q, nflg;

  assign adv = !v3 | out_ready;
  assign in_ready = adv;
  assign out_valid = v3;
  assign result = res_q;
  assign flags = flg_q;

  fp27_t a, b, big, sml;
  logic  a_zero, a_inf, a_nan;
  logic  b_zero, b_inf, b_nan;

  always_comb begin
    a = op_a;
    b = op_b;
    b.sign = op_b[EXP_W+FRAC_W] ^ sub;
    a_zero = a.exp == '0;
    a_inf = (&a.exp) & ~(|a.frac);
    a_nan = (&a.exp) & (|a.frac);
    b_zero = b.exp == '0;
    b_inf = (&b.exp) & ~(|b.frac);
    b_nan = (&b.exp) & (|b.frac);
    if ({b.exp, b.frac} > {a.exp, a.frac}) begin
      big = b;
      sml = a;
    end else begin
      big = a;
      sml = b;
    end
    al_d = '0;
    al_d.sign = big.sign;
    al_d.exp = big.exp;
    al_d.eff_sub = big.sign ^ sml.sign;
    al_d.ma = {1'b1, big.frac, 3'b000};
    al_d.mb = align_sig({1'b1, sml.frac}, big.exp - sml.exp);
    al_d.byp = 1'b1;
    // Specials bypass the arithmetic; order encodes precedence.
    if (a_nan | b_nan | (a_inf & b_inf & (a.sign ^ b.sign))) begin
      al_d.res = FP27_QNAN;
      al_d.flg = 3'b001;
    end else if (a_inf) begin
      al_d.res = a;
    end else if (b_inf) begin
      al_d.res = b;
    end else if (a_zero & b_zero) begin
      al_d.res = {a.sign & b.sign, {(W-1){1'b0}}};
    end else if (a_zero) begin
      al_d.res = b;
    end else if (b_zero) begin
      al_d.res = a;
    end else begin
      al_d.byp = 1'b0;
    end
  end

  always_comb begin
    ad_d = '0;
    ad_d.byp = s1.byp;
    ad_d.res = s1.res;
    ad_d.flg = s1.flg;
    ad_d.sign = s1.sign;
    ad_d.exp = s1.exp;
    if (s1.eff_sub)
      ad_d.sum = {1'b0, s1.ma} - {1'b0, s1.mb};
    else
      ad_d.sum = {1'b0, s1.ma} + {1'b0, s1.mb};
  end

  logic [4:0]         lz;
  logic [AL_W-1:0]    nm;
  logic signed [9:0]  e;
  logic [FRAC_W-1:0]  frac;

  fp_lzc u_lzc (
    .d   ({s2.sum[AL_W-1:0], 1'b1}),
    .cnt (lz)
  );

  always_comb begin
    nm = '0;
    e = '0;
    nres = '0;
    nflg = '0;
    if (s2.sum[AL_W]) begin
      nm = {s2.sum[AL_W:2], |s2.sum[1:0]};
      e = $signed({2'b00, s2.exp}) + 10'sd1;
    end else begin
      nm = s2.sum[AL_W-1:0] << lz;
      e = $signed({2'b00, s2.exp}) - $signed({5'b00000, lz});
    end
    frac = nm[FRAC_W+2:3];
`ifdef FP_ADDSUB_RNE_EN
    begin
      logic rc;
      rc = 1'b0;
      if (nm[2] & (nm[1] | nm[0] | nm[3])) begin
        {rc, frac} = {1'b0, frac} + 19'd1;
        if (rc) e = e + 10'sd1;
      end
    end
`endif
    if (s2.byp) begin
      nres = s2.res;
      nflg = s2.flg;
    end else if (nm == '0) begin
      nres = '0;
    end else if (e >= 10'sd255) begin
      nres = {s2.sign, 8'hFF, {FRAC_W{1'b0}}};
      nflg = 3'b100;
    end else if (e <= 10'sd0) begin
      nres = {s2.sign, {(W-1){1'b0}}};
      nflg = 3'b010;
    end else begin
      nres = {s2.sign, e[7:0], frac};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      res_q <= '0;
      flg_q <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      s1 <= al_d;
      s2 <= ad_d;
      res_q <= nres;
      flg_q <= nflg;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe against an exact-arithmetic model.
// Honours FP_ADDSUB_RNE_EN to select the rounding mode of the model.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [26:0] op_a, op_b;
  logic        sub;
  logic        out_valid, out_ready;
  logic [26:0] result;
  logic [2:0]  flags;

  int n_cmp = 0;
  int n_bad = 0;
  logic [29:0] expq[$];

  fp_addsub_pipe #(.EXP_W(8), .FRAC_W(18)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  // Exact value of A +/- B, then truncated (or RNE) to 18 fraction bits.
  function automatic logic [29:0] ref_op(
    input logic [26:0] a, input logic [26:0] b, input logic s
  );
    logic sa, sb, anan, bnan, ainf, binf, neg;
    int ea, eb, emin, p, e;
    longint ma, mb, sum, m, q, low;
    sa = a[26];
    sb = b[26] ^ s;
    ea = int'(a[25:18]);
    eb = int'(b[25:18]);
    anan = ea == 255 && a[17:0] != 0;
    bnan = eb == 255 && b[17:0] != 0;
    ainf = ea == 255 && a[17:0] == 0;
    binf = eb == 255 && b[17:0] == 0;
    if (anan || bnan || (ainf && binf && sa != sb))
      return {3'b001, 27'h3FE0000};
    if (ainf) return {3'b000, a};
    if (binf) return {3'b000, sb, b[25:0]};
    if (ea == 0 && eb == 0) return {3'b000, sa & sb, 26'h0};
    if (ea == 0) return {3'b000, sb, b[25:0]};
    if (eb == 0) return {3'b000, a};
    emin = (ea < eb) ? ea : eb;
    ma = longint'({1'b1, a[17:0]}) << (ea - emin);
    mb = longint'({1'b1, b[17:0]}) << (eb - emin);
    sum = (sa ? -ma : ma) + (sb ? -mb : mb);
    if (sum == 0) return 30'h0;
    neg = sum < 0;
    m = neg ? -sum : sum;
    p = 62;
    while (!m[p]) p--;
    e = emin + p - 18;
    if (p >= 18) q = m >> (p - 18);
    else q = m << (18 - p);
`ifdef FP_ADDSUB_RNE_EN
    if (p > 18) begin
      low = (p > 19) ? (m & ((longint'(1) << (p - 19)) - 1)) : 0;
      if (m[p-19] && (low != 0 || q[0])) begin
        q = q + 1;
        if (q == (longint'(1) << 19)) begin
          q = q >> 1;
          e = e + 1;
        end
      end
    end
`else
    low = 0;
`endif
    if (e >= 255) return {3'b100, neg, 8'hFF, 18'h0};
    if (e <= 0) return {3'b010, neg, 26'h0};
    return {3'b000, neg, 8'(e), q[17:0]};
  endfunction

  task automatic drive(
    input logic v, input logic [26:0] a, input logic [26:0] b,
    input logic s, input logic rdy
  );
    @(negedge clk);
    in_valid = v;
    op_a = a;
    op_b = b;
    sub = s;
    out_ready = rdy;
    #1;
  endtask

  task automatic gen_op(output logic [26:0] a, output logic [26:0] b,
                        output logic s);
    int e1, e2;
    e1 = int'($urandom_range(1, 254));
    e2 = e1 + int'($urandom_range(0, 80)) - 40;
    if (e2 < 1) e2 = 1;
    if (e2 > 254) e2 = 254;
    if ($urandom_range(0, 19) == 0) e1 = $urandom_range(0, 1) ? 0 : 255;
    if ($urandom_range(0, 19) == 0) e2 = $urandom_range(0, 1) ? 0 : 255;
    a = {1'($urandom), 8'(e1), 18'($urandom)};
    b = {1'($urandom), 8'(e2), 18'($urandom)};
    if ($urandom_range(0, 3) == 0)
      b = {b[26], a[25:18], a[17:0] ^ 18'($urandom_range(0, 3))};
    s = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    sub = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp += 4;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    if (result !== 27'h0) begin
      n_bad++; $display("FAIL reset_result: got %h want 0", result);
    end
    if (flags !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", flags);
    end
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  typedef struct {
    logic [26:0] a, b;
    logic        s;
    logic [26:0] r;
    logic [2:0]  f;
  } vec_t;

  task automatic test_directed();
    vec_t vs[$];
    logic [26:0] rne_r;
`ifdef FP_ADDSUB_RNE_EN
    rne_r = 27'h1FC0002;
`else
    rne_r = 27'h1FC0001;
`endif
    vs.push_back('{27'h1FC0000, 27'h1FC0000, 1'b0, 27'h2000000, 3'b000});
    vs.push_back('{27'h2000000, 27'h1FC0000, 1'b0, 27'h2020000, 3'b000});
    vs.push_back('{27'h1FC0000, 27'h1FC0000, 1'b1, 27'h0000000, 3'b000});
    vs.push_back('{27'h3FBFFFF, 27'h3FBFFFF, 1'b0, 27'h3FC0000, 3'b100});
    vs.push_back('{27'h3FC0000, 27'h3FC0000, 1'b1, 27'h3FE0000, 3'b001});
    vs.push_back('{27'h1FC0001, 27'h0BC0000, 1'b0, 27'h1FC0001, 3'b000});
    vs.push_back('{27'h1FC0001, 27'h1B00000, 1'b0, rne_r, 3'b000});
    vs.push_back('{27'h0000000, 27'h1FC0000, 1'b1, 27'h5FC0000, 3'b000});
    vs.push_back('{27'h4000000, 27'h0000000, 1'b1, 27'h4000000, 3'b000});
    vs.push_back('{27'h0000000, 27'h4000000, 1'b0, 27'h0000000, 3'b000});
    vs.push_back('{27'h3FC0000, 27'h2000000, 1'b1, 27'h3FC0000, 3'b000});
    vs.push_back('{27'h2000000, 27'h7FC0000, 1'b0, 27'h7FC0000, 3'b000});
    vs.push_back('{27'h3FC0005, 27'h1FC0000, 1'b0, 27'h3FE0000, 3'b001});
    vs.push_back('{27'h0040001, 27'h0040000, 1'b1, 27'h0000000, 3'b010});
    foreach (vs[i]) begin
      drive(1'b1, vs[i].a, vs[i].b, vs[i].s, 1'b1);
      for (int k = 1; k <= 2; k++) begin
        drive(1'b0, 27'h0, 27'h0, 1'b0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL latency_early vec%0d cyc%0d: out_valid %b want 0",
                   i, k, out_valid);
        end
      end
      drive(1'b0, 27'h0, 27'h0, 1'b0, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || result !== vs[i].r || flags !== vs[i].f) begin
        n_bad++;
        $display("FAIL directed vec%0d: got v=%b %h/%b want v=1 %h/%b",
                 i, out_valid, result, flags, vs[i].r, vs[i].f);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [26:0] ba[5], bb[5];
    logic        bs[5];
    logic [29:0] held, ex;
    int idx, got;
    logic rdy;
    expq.delete();
    for (int i = 0; i < 5; i++) gen_op(ba[i], bb[i], bs[i]);
    idx = 0;
    got = 0;
    held = '0;
    for (int c = 0; c < 30; c++) begin
      rdy = !(c >= 3 && c < 7);
      if (idx < 5) drive(1'b1, ba[idx], bb[idx], bs[idx], rdy);
      else drive(1'b0, 27'h0, 27'h0, 1'b0, rdy);
      if (!rdy) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_bad++; $display("FAIL b2b_in_ready c%0d: got %b want 0", c, in_ready);
        end
        if (c == 3) held = {flags, result};
        else begin
          n_cmp++;
          if ({flags, result} !== held) begin
            n_bad++;
            $display("FAIL b2b_stable c%0d: got %h want %h", c,
                     {flags, result}, held);
          end
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++; $display("FAIL b2b_extra c%0d: got %h want none", c, result);
        end else begin
          ex = expq.pop_front();
          got++;
          if ({flags, result} !== ex) begin
            n_bad++;
            $display("FAIL b2b_order n%0d: got %h want %h", got,
                     {flags, result}, ex);
          end
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_op(ba[idx], bb[idx], bs[idx]));
        idx++;
      end
    end
    n_cmp++;
    if (got != 5 || expq.size() != 0) begin
      n_bad++; $display("FAIL b2b_count: got %0d results want 5", got);
    end
  endtask

  task automatic test_random();
    logic [26:0] a, b;
    logic s, v, rdy;
    logic [29:0] ex;
    int sent;
    sent = 0;
    expq.delete();
    for (int c = 0; c < 3000 && (sent < 200 || expq.size() > 0); c++) begin
      gen_op(a, b, s);
      v = (sent < 200) && ($urandom_range(0, 3) != 0);
      rdy = $urandom_range(0, 3) != 0;
      drive(v, a, b, s, rdy);
      if (out_valid && out_ready) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++; $display("FAIL rand_extra c%0d: got %h want none", c, result);
        end else begin
          ex = expq.pop_front();
          if ({flags, result} !== ex) begin
            n_bad++;
            $display("FAIL rand_result c%0d: got %h want %h", c,
                     {flags, result}, ex);
          end
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_op(a, b, s));
        sent++;
      end
    end
    n_cmp++;
    if (sent != 200 || expq.size() != 0) begin
      n_bad++;
      $display("FAIL rand_drain: sent %0d pending %0d want 200/0", sent,
               expq.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic [26:0] na, nb;
    logic ns;
    logic [29:0] ex;
    int outs;
    drive(1'b1, 27'h1FC0000, 27'h1FC0000, 1'b0, 1'b1);
    drive(1'b1, 27'h2000000, 27'h1FC0000, 1'b0, 1'b1);
    drive(1'b0, 27'h0, 27'h0, 1'b0, 1'b0);
    drive(1'b0, 27'h0, 27'h0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre: out_valid %b want 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || result !== 27'h0) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b %h want v=0 0", out_valid, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    gen_op(na, nb, ns);
    ex = ref_op(na, nb, ns);
    drive(1'b1, na, nb, ns, 1'b1);
    outs = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 27'h0, 27'h0, 1'b0, 1'b1);
      if (out_valid) begin
        outs++;
        n_cmp++;
        if (outs > 1 || {flags, result} !== ex) begin
          n_bad++;
          $display("FAIL mid_first n%0d: got %h want %h", outs,
                   {flags, result}, ex);
        end
      end
    end
    n_cmp++;
    if (outs != 1) begin
      n_bad++; $display("FAIL mid_count: got %0d outputs want 1", outs);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
